// File: rtl/bayer_pkg.sv
// Shared types for the Bayer window controller: FSM state encoding,
// pixel word and the four-pixel window handed to the channel mux.
package bayer_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef struct packed {
    pixel_t wb_1;  // top-left
    pixel_t wb_2;  // top-right
    pixel_t wb_3;  // bottom-left
    pixel_t wb_4;  // bottom-right
  } window_t;

endpackage

// File: rtl/bayer_window_ctrl_if.sv
// Pixel-in / window-out bus of the Bayer window controller.
// master = upstream/downstream environment, slave = the controller.
interface bayer_window_ctrl_if #(
  parameter int PIX_W = 8
);

  logic             start;
  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] wb_1;
  logic [PIX_W-1:0] wb_2;
  logic [PIX_W-1:0] wb_3;
  logic [PIX_W-1:0] wb_4;
  logic             row;
  logic             col;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, wb_1, wb_2, wb_3, wb_4, row, col, busy, frame_done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, wb_1, wb_2, wb_3, wb_4, row, col, busy, frame_done
  );

endinterface

// File: rtl/bayer_line_buf.sv
// One-line pixel history: combinational read and synchronous write at the
// same address, so a column's old value is read while its new one is stored.
module bayer_line_buf #(
  parameter int WIDTH = 640,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [WIDTH];

  // Store the accepted pixel over the column it replaces.
  // NOTE: no reset on the array; row 0 of every frame rewrites every entry
  // before it is ever read as a top pixel, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bayer_window_ctrl.sv
// Streaming controller feeding 2x2 Bayer windows to the rggb channel mux.
// Keeps one line of history plus the previous column's top/bottom pixels and
// emits one window per accepted pixel with row >= 1 and column >= 1.
module bayer_window_ctrl
  import bayer_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = PIX_W_DEF
) (
  input logic               clk,
  input logic               rst,
  bayer_window_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  state_t           state, state_n;
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic [CW-1:0]    col_m1;
  logic [RW-1:0]    row_m1;
  logic [PIX_W-1:0] top;
  logic [PIX_W-1:0] prev_top;
  logic [PIX_W-1:0] prev_bot;
  logic [PIX_W-1:0] wb_1_q, wb_2_q, wb_3_q, wb_4_q;
  logic             row_q, col_q;
  logic             out_valid_q;
  logic             frame_done_q, frame_done_n;
  logic             in_ready_int;
  logic             accept;
  logic             win_load;
  logic             last_col, last_row;

  assign last_col = (col_cnt == CW'(WIDTH - 1));
  assign last_row = (row_cnt == RW'(HEIGHT - 1));
  assign col_m1   = col_cnt - 1'b1;
  assign row_m1   = row_cnt - 1'b1;

  // The output slot is free when empty or being drained this cycle.
  assign in_ready_int = ((state == FILL) || (state == STREAM)) &&
                        (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && in_ready_int;
  assign win_load     = accept && (row_cnt != '0) && (col_cnt != '0);

  bayer_line_buf #(
    .WIDTH (WIDTH),
    .PIX_W (PIX_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cnt),
    .wdata (bus.in_data),
    .rdata (top)
  );

  // State register and the registered end-of-frame pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      frame_done_q <= frame_done_n;
    end
  end

  // Next-state logic: frame sequencing IDLE -> FILL -> STREAM -> DRAIN.
  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_n      = state;
    frame_done_n = 1'b0;
    unique case (state)
      IDLE:    if (bus.start) state_n = FILL;
      FILL:    if (accept && last_col) state_n = STREAM;
      STREAM:  if (accept && last_col && last_row) state_n = DRAIN;
      DRAIN: begin
        if (!out_valid_q || bus.out_ready) begin
          state_n      = IDLE;
          frame_done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && bus.start)) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Left column of the next window: previous top and bottom pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_top <= '0;
      prev_bot <= '0;
    end else if (accept) begin
      prev_top <= top;
      prev_bot <= bus.in_data;
    end
  end

  // Output register: loads a window, holds it under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wb_1_q      <= '0;
      wb_2_q      <= '0;
      wb_3_q      <= '0;
      wb_4_q      <= '0;
      row_q       <= 1'b0;
      col_q       <= 1'b0;
    end else if (win_load) begin
      out_valid_q <= 1'b1;
      wb_1_q      <= prev_top;
      wb_2_q      <= top;
      wb_3_q      <= prev_bot;
      wb_4_q      <= bus.in_data;
      row_q       <= ~row_m1[0];
      col_q       <= col_m1[0];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = out_valid_q;
  assign bus.wb_1       = wb_1_q;
  assign bus.wb_2       = wb_2_q;
  assign bus.wb_3       = wb_3_q;
  assign bus.wb_4       = wb_4_q;
  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bayer_window_ctrl.sv
// Scoreboard bench for bayer_window_ctrl on a 4x3 frame: the driver pushes
// the window each accepted pixel should produce, the monitor pops and
// compares on every output transfer.
module tb_bayer_window_ctrl;
  import bayer_pkg::*;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int PW   = 8;
  localparam int NWIN = (W - 1) * (H - 1);

  typedef struct {
    window_t win;
    logic    row;
    logic    col;
    int      exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bayer_window_ctrl_if #(.PIX_W(PW)) ifc ();

  bayer_window_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .PIX_W  (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  exp_t             sb[$];
  logic [4*PW+1:0]  obs[$];
  pixel_t           img [H][W];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, xfer_cnt = 0, last_xfer_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares each transferred window, its latency, hold stability
  // under backpressure and the frame_done pulse.
  logic            prev_valid = 0, prev_xfer = 0, prev_stall = 0, prev_done = 0;
  logic [4*PW+1:0] held = '0, cur;
  int              present_cyc = 0;
  exp_t            e_m;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_valid = 0; prev_xfer = 0; prev_stall = 0; prev_done = 0;
    end else begin
      cur = {ifc.wb_1, ifc.wb_2, ifc.wb_3, ifc.wb_4, ifc.row, ifc.col};
      if (prev_stall) begin
        check("hold_valid", ifc.out_valid, 1);
        check("hold_stable", cur, held);
      end
      if (ifc.out_valid) begin
        if (!prev_valid || prev_xfer) present_cyc = cyc;
        if (!ifc.out_ready) begin
          check("stall_in_ready", ifc.in_ready, 0);
          held = cur;
        end else begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_window: got %0h, expected no window", cur);
          end else begin
            e_m = sb.pop_front();
            check("window", cur, {e_m.win, e_m.row, e_m.col});
            check("window_latency", present_cyc, e_m.exp_cyc);
          end
          obs.push_back(cur);
          xfer_cnt++;
          last_xfer_cyc = cyc;
        end
      end
      if (ifc.frame_done) begin
        check("done_latency", cyc, last_xfer_cyc + 1);
        check("done_sb_empty", sb.size(), 0);
        check("done_single_cycle", prev_done, 0);
        done_cnt++;
      end
      prev_valid = ifc.out_valid;
      prev_xfer  = ifc.out_valid && ifc.out_ready;
      prev_stall = ifc.out_valid && !ifc.out_ready;
      prev_done  = ifc.frame_done;
    end
  end

  // Drives one frame. rand_pix: random data else r*16+c; bubbles: in_valid
  // toggles; stall_len: out_ready held low once mid-frame; start_mid: start
  // pulsed in STREAM; abort: reset right after pixel (1,2); quick: start
  // without idling a cycle first.
  task automatic run_frame(input bit rand_pix, input bit bubbles, input int stall_len,
                           input bit start_mid, input bit abort, input bit quick);
    int r = 0, c = 0, budget = 0, stall_left = 0, done0, xfer0;
    bit stalled = 0, tog = 0, aborted = 0;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        img[rr][cc] = rand_pix ? pixel_t'($urandom) : pixel_t'(rr * 16 + cc);
    done0 = done_cnt;
    xfer0 = xfer_cnt;
    if (!quick) @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    #1 check("busy_after_start", ifc.busy, 1);
    while (r < H && budget < 500 && !aborted) begin
      @(negedge clk);
      budget++;
      if (stall_len > 0 && !stalled && ifc.out_valid && r == 1 && c == 3) begin
        stall_left = stall_len;
        stalled    = 1;
      end
      ifc.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      ifc.start    = start_mid && r == 1 && c == 1;
      tog          = ~tog;
      ifc.in_valid = bubbles ? tog : 1'b1;
      ifc.in_data  = img[r][c];
      #1;
      if (ifc.in_valid && ifc.in_ready) begin
        if (r >= 1 && c >= 1)
          sb.push_back('{win: {img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c]},
                         row: ((r - 1) % 2 == 0), col: ((c - 1) % 2 == 1),
                         exp_cyc: cyc + 1});
        if (abort && r == 1 && c == 2) aborted = 1;
        c++;
        if (c == W) begin c = 0; r++; end
      end
    end
    if (abort) begin
      @(negedge clk);
      rst = 1'b1; ifc.in_valid = 1'b0; ifc.start = 1'b0; ifc.out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("abort_busy", ifc.busy, 0);
      check("abort_out_valid", ifc.out_valid, 0);
      check("abort_in_ready", ifc.in_ready, 0);
      check("abort_frame_done", ifc.frame_done, 0);
      sb.delete();
      rst = 1'b0;
      repeat (6) @(negedge clk);
      #3 check("abort_no_done", done_cnt - done0, 0);
    end else begin
      check("pixels_accepted", r, H);
      budget = 0;
      while (done_cnt == done0 && budget < 100) begin
        @(negedge clk);
        ifc.in_valid = 1'b0; ifc.start = 1'b0; ifc.out_ready = 1'b1;
        budget++;
        #3;
      end
      check("frame_done_seen", done_cnt - done0, 1);
      check("window_count", xfer_cnt - xfer0, NWIN);
      check("idle_after_done", ifc.busy, 0);
    end
  endtask

  task automatic check_pattern_windows();
    logic [4*PW+1:0] w;
    check("obs_count", obs.size(), NWIN);
    if (obs.size() >= 4) begin
      w = obs[0]; check("first_window",  w, {8'h00, 8'h01, 8'h10, 8'h11, 1'b1, 1'b0});
      w = obs[1]; check("second_window", w, {8'h01, 8'h02, 8'h11, 8'h12, 1'b1, 1'b1});
      w = obs[3]; check("fourth_window", w, {8'h10, 8'h11, 8'h20, 8'h21, 1'b0, 1'b0});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish by 100000 ns");
    $fatal(1);
  end

  initial begin
    ifc.start = 0; ifc.in_valid = 0; ifc.in_data = '0; ifc.out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_wb", {ifc.wb_1, ifc.wb_2, ifc.wb_3, ifc.wb_4}, 0);
    check("rst_row_col", {ifc.row, ifc.col}, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_frame_done", ifc.frame_done, 0);
    rst = 1'b0;

    obs.delete();
    run_frame(0, 0, 0, 0, 0, 0);   // plain pattern frame
    check_pattern_windows();
    run_frame(1, 1, 0, 0, 0, 0);   // random data, upstream bubbles
    obs.delete();
    run_frame(0, 0, 5, 0, 0, 0);   // backpressure
    check_pattern_windows();
    run_frame(1, 0, 0, 1, 0, 0);   // start ignored in STREAM
    run_frame(0, 0, 0, 0, 1, 0);   // reset mid-frame
    obs.delete();
    run_frame(0, 0, 0, 0, 0, 0);   // fresh frame after abort
    check_pattern_windows();
    run_frame(1, 1, 3, 0, 0, 0);   // random frame, then back-to-back pattern
    obs.delete();
    run_frame(0, 0, 0, 0, 0, 1);
    check_pattern_windows();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
